endian_swap_pipe: RTL

Parametrised, pipelined endian/bit-order converter with valid/ready handshakes on both sides. Each accepted word is transformed by a per-beat mode: pass-through, full bit reversal, byte-order swap, or bit reversal within each byte. The result is presented one cycle later through a 2-entry skid buffer, so throughput is one word per cycle under back-pressure. The block sits on streaming datapaths between bus interfaces of differing byte/bit order.

---
 rtl/endian_pkg.sv | 15 +
 rtl/endian_swap_comb.sv | 43 ++++
 rtl/endian_swap_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/endian_pkg.sv
// Shared mode encodings and skid-buffer state type for the endian swap pipe.
package endian_pkg;

  localparam logic [1:0] MODE_PASS      = 2'b00;
  localparam logic [1:0] MODE_BITREV    = 2'b01;
  localparam logic [1:0] MODE_BYTESWAP  = 2'b10;
  localparam logic [1:0] MODE_BITINBYTE = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

endpackage

// File: rtl/endian_swap_comb.sv
// Purely combinational word transform: pass, full bit reverse, byte swap,
// or bit reverse inside each byte.
module endian_swap_comb
  import endian_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] rev_data;
  logic [DATA_W-1:0] bswap_data;
  logic [DATA_W-1:0] binb_data;

  genvar gi, gj;

  for (gi = 0; gi < DATA_W; gi++) begin : g_rev
    assign rev_data[gi] = data_in[DATA_W-1-gi];
  end

  for (gi = 0; gi < NB; gi++) begin : g_byte
    assign bswap_data[gi*8 +: 8] = data_in[(NB-1-gi)*8 +: 8];
    for (gj = 0; gj < 8; gj++) begin : g_bit
      assign binb_data[gi*8+gj] = data_in[gi*8+7-gj];
    end
  end

  // Select the transform requested for this beat.
  always_comb begin
    data_out = data_in;
    case (mode)
      MODE_BITREV:    data_out = rev_data;
      MODE_BYTESWAP:  data_out = bswap_data;
      MODE_BITINBYTE: data_out = binb_data;
      default:        data_out = data_in;
    endcase
  end

endmodule

// File: rtl/endian_swap_pipe.sv
// Pipelined endian/bit-order converter with a 2-entry skid buffer.
// Words are transformed on the way in; main drives m_*, skid catches the
// one extra word accepted when downstream stalls.
module endian_swap_pipe
  import endian_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [1:0]        s_mode,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_mode,
  output logic              busy
);

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
    $error("endian_swap_pipe: DATA_W must be a multiple of 8 and at least 8");
  end

  state_t            state_q, state_d;
  logic              s_ready_q;
  logic [DATA_W-1:0] xf_data;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [1:0]        main_mode, skid_mode;
  logic              accept, xfer;
  logic              load_main_in, load_skid, load_main_skid;

  endian_swap_comb #(.DATA_W(DATA_W)) u_swap (
    .mode     (s_mode),
    .data_in  (s_data),
    .data_out (xf_data)
  );

  assign accept = s_valid && s_ready_q;
  assign xfer   = (state_q != ST_EMPTY) && m_ready;

  // Next-state and register load selects.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !xfer) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (accept && xfer) begin
          load_main_in = 1'b1;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State register; s_ready is registered from the next state so it never
  // sees m_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != ST_TWO);
    end
  end

  // Main and skid data/mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_mode <= '0;
      skid_data <= '0;
      skid_mode <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= xf_data;
        main_mode <= s_mode;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_mode <= skid_mode;
      end
      if (load_skid) begin
        skid_data <= xf_data;
        skid_mode <= s_mode;
      end
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = (state_q != ST_EMPTY);
  assign busy    = (state_q != ST_EMPTY);
  assign m_data  = main_data;
  assign m_mode  = main_mode;

endmodule
